// File: rtl/decode_scoreboard_if.sv
// Decode/writeback bundle between the decode stage and the RAW scoreboard.
// master: decode stage (drives issue, writeback mirror and flush; samples status)
// slave : scoreboard  (samples issue/writeback/flush; drives stall, issue_fire,
//         pending_mask, err)
interface decode_scoreboard_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3
);
    logic                issue_valid;
    logic [SEL_W-1:0]    issue_rs_sel;
    logic                issue_rs_used;
    logic [SEL_W-1:0]    issue_rt_sel;
    logic                issue_rt_used;
    logic [SEL_W-1:0]    issue_wr_sel;
    logic                issue_wr_en;
    logic                wb_writeEn;
    logic [SEL_W-1:0]    wb_writeRegSel;
    logic                flush;
    logic                stall;
    logic                issue_fire;
    logic [NUM_REGS-1:0] pending_mask;
    logic                err;

    modport master (
        output issue_valid, issue_rs_sel, issue_rs_used, issue_rt_sel,
               issue_rt_used, issue_wr_sel, issue_wr_en,
               wb_writeEn, wb_writeRegSel, flush,
        input  stall, issue_fire, pending_mask, err
    );

    modport slave (
        input  issue_valid, issue_rs_sel, issue_rs_used, issue_rt_sel,
               issue_rt_used, issue_wr_sel, issue_wr_en,
               wb_writeEn, wb_writeRegSel, flush,
        output stall, issue_fire, pending_mask, err
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode-stage RAW hazard unit. Tracks a pending-write counter per register:
// incremented when a writer issues, decremented by the writeback strobe.
// Writeback is bypassed into same-cycle reads, so a retiring register counts
// as ready for the stall decision.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - decode_scoreboard_if.slave: issue request, writeback mirror,
//           flush in; stall, issue_fire, pending_mask, sticky err out
module decode_scoreboard #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_scoreboard_if.slave bus
);
    logic [CNT_W-1:0]    cnt      [NUM_REGS];
    logic [CNT_W-1:0]    effCnt   [NUM_REGS];
    logic [NUM_REGS-1:0] retHit;
    logic [NUM_REGS-1:0] issueHit;
    logic [NUM_REGS-1:0] effBusy;
    logic                rsBusy;
    logic                rtBusy;
    logic                wrFull;
    logic                errReg;

    // Effective count: pending writes left after this cycle's writeback.
    // A retire against an empty counter does not underflow.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            retHit[r]   = bus.wb_writeEn && (bus.wb_writeRegSel == SEL_W'(r));
            issueHit[r] = bus.issue_fire && bus.issue_wr_en
                          && (bus.issue_wr_sel == SEL_W'(r));
            effCnt[r]   = (cnt[r] != '0) ? (cnt[r] - CNT_W'(retHit[r])) : '0;
            effBusy[r]  = (effCnt[r] != '0);
        end
    end

    always_comb begin
        rsBusy = bus.issue_rs_used && (effCnt[bus.issue_rs_sel] != '0);
        rtBusy = bus.issue_rt_used && (effCnt[bus.issue_rt_sel] != '0);
        wrFull = bus.issue_wr_en && (effCnt[bus.issue_wr_sel] == CNT_W'(MAX_PEND));
    end

    assign bus.stall        = bus.issue_valid && (rsBusy || rtBusy || wrFull);
    assign bus.issue_fire   = bus.issue_valid && !bus.stall && !bus.flush;
    assign bus.pending_mask = effBusy;
    assign bus.err          = errReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            errReg <= 1'b0;
        end else if (bus.flush) begin
            // Flush drops everything in flight, including a same-cycle retire,
            // which therefore cannot raise err.
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (retHit[r] && (cnt[r] == '0)) begin
                    // Spurious retire: flag it and ignore the decrement; a
                    // same-cycle issue still counts.
                    errReg <= 1'b1;
                    cnt[r] <= cnt[r] + CNT_W'(issueHit[r]);
                end else begin
                    cnt[r] <= cnt[r] + CNT_W'(issueHit[r]) - CNT_W'(retHit[r]);
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed test of decode_scoreboard: hazard stall, bypassed retire,
// full-counter stall, issue/retire netting, sticky err, flush and async reset.
module tb_decode_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_scoreboard_if #(.NUM_REGS(8), .SEL_W(3)) bus ();

    decode_scoreboard #(
        .NUM_REGS(8),
        .SEL_W(3),
        .CNT_W(2),
        .MAX_PEND(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.issue_rs_sel   = '0;
        bus.issue_rs_used  = 1'b0;
        bus.issue_rt_sel   = '0;
        bus.issue_rt_used  = 1'b0;
        bus.issue_wr_sel   = '0;
        bus.issue_wr_en    = 1'b0;
        bus.wb_writeEn     = 1'b0;
        bus.wb_writeRegSel = '0;
        bus.flush          = 1'b0;
    endtask

    task automatic issueWr(input logic [2:0] r);
        idle();
        bus.issue_valid  = 1'b1;
        bus.issue_wr_en  = 1'b1;
        bus.issue_wr_sel = r;
    endtask

    task automatic retire(input logic [2:0] r);
        bus.wb_writeEn     = 1'b1;
        bus.wb_writeRegSel = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_stall", bus.stall, 0);
        chk("rst_fire", bus.issue_fire, 0);
        chk("rst_mask", bus.pending_mask, 8'h00);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        tick();

        // 1: writer of r3, then reader of r3 stalls
        issueWr(3'd3);
        #1 chk("t1_wr_fire", bus.issue_fire, 1);
        tick();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rs_used = 1'b1; bus.issue_rs_sel = 3'd3;
        #1 chk("t1_rs_stall", bus.stall, 1);
        chk("t1_rs_fire", bus.issue_fire, 0);
        chk("t1_mask", bus.pending_mask, 8'h08);
        bus.issue_rs_used = 1'b0;
        #1 chk("t1_rs_unused", bus.stall, 0);
        bus.issue_rt_used = 1'b1; bus.issue_rt_sel = 3'd3;
        #1 chk("t1_rt_stall", bus.stall, 1);
        tick();

        // 2: bypassed retire lets the reader go
        idle();
        bus.issue_valid = 1'b1; bus.issue_rs_used = 1'b1; bus.issue_rs_sel = 3'd3;
        retire(3'd3);
        #1 chk("t2_stall", bus.stall, 0);
        chk("t2_fire", bus.issue_fire, 1);
        tick();
        idle();
        #1 chk("t2_mask", bus.pending_mask, 8'h00);
        chk("t2_err", bus.err, 0);

        // 3: three writers to r5 fill it, fourth stalls unless r5 retires
        for (int i = 0; i < 3; i++) begin
            issueWr(3'd5);
            #1 chk("t3_fill_fire", bus.issue_fire, 1);
            tick();
        end
        issueWr(3'd5);
        #1 chk("t3_full_stall", bus.stall, 1);
        chk("t3_mask", bus.pending_mask, 8'h20);
        retire(3'd5);
        #1 chk("t3_ret_stall", bus.stall, 0);
        chk("t3_ret_fire", bus.issue_fire, 1);
        tick();
        idle();
        bus.issue_valid = 1'b1; bus.issue_wr_en = 1'b1; bus.issue_wr_sel = 3'd5;
        #1 chk("t3_still_full", bus.stall, 1);
        idle();
        for (int i = 0; i < 3; i++) begin
            retire(3'd5);
            tick();
        end
        idle();
        #1 chk("t3_drained", bus.pending_mask, 8'h00);
        chk("t3_err", bus.err, 0);

        // 4: same-cycle issue and retire of r2 nets to zero
        issueWr(3'd2);
        tick();
        issueWr(3'd2);
        retire(3'd2);
        #1 chk("t4_fire", bus.issue_fire, 1);
        tick();
        idle();
        #1 chk("t4_mask", bus.pending_mask, 8'h04);
        retire(3'd2);
        tick();
        idle();
        #1 chk("t4_drained", bus.pending_mask, 8'h00);
        chk("t4_err", bus.err, 0);

        // 5: retire of empty r6 sets sticky err; issue+retire on empty gives +1
        retire(3'd6);
        #1 chk("t5_err_pre", bus.err, 0);
        tick();
        idle();
        #1 chk("t5_err_set", bus.err, 1);
        chk("t5_mask_zero", bus.pending_mask, 8'h00);
        issueWr(3'd6);
        retire(3'd6);
        tick();
        idle();
        #1 chk("t5_plus_one", bus.pending_mask, 8'h40);
        retire(3'd6);
        tick();
        idle();
        #1 chk("t5_drained", bus.pending_mask, 8'h00);
        chk("t5_err_sticky", bus.err, 1);

        // 6: flush with pending r1/r4 and a retire in the same cycle
        issueWr(3'd1);
        tick();
        issueWr(3'd4);
        tick();
        idle();
        #1 chk("t6_mask", bus.pending_mask, 8'h12);
        issueWr(3'd7);
        bus.flush = 1'b1;
        retire(3'd1);
        #1 chk("t6_fire", bus.issue_fire, 0);
        tick();
        idle();
        #1 chk("t6_mask_clr", bus.pending_mask, 8'h00);
        chk("t6_err_kept", bus.err, 1);

        // Asynchronous reset mid-operation
        issueWr(3'd3);
        tick();
        idle();
        #1 chk("ar_mask_pre", bus.pending_mask, 8'h08);
        #1 rst_n = 1'b0;
        #1 chk("ar_mask", bus.pending_mask, 8'h00);
        chk("ar_err", bus.err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Flush discards a retire of an empty register without raising err
        idle();
        bus.flush = 1'b1;
        retire(3'd0);
        tick();
        idle();
        #1 chk("fl_no_err", bus.err, 0);
        chk("fl_mask", bus.pending_mask, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
